nh_lcd_bus_responder: RTL and testbench

Peripheral-side responder for the 8-bit 8080-style parallel LCD bus that the host command engine drives. It samples the host's write/read strobes, chip select and command/parameter line, and decodes a small ILI-class command subset (column/page window set, memory write, read ID). Memory-write bytes are assembled into 16-bit pixels with window-wrapping X/Y addresses. It serves as the bus-functional display model in the wb_nh_lcd simulation and FPGA loopback tests.

---
 rtl/nh_lcd_bus_responder.sv | 257 +++++++++++++++++++++++++
 tb/tb_nh_lcd_bus_responder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/nh_lcd_bus_responder.sv
// Bus-functional display model for the 8080-style 8-bit LCD bus: decodes CASET/PASET/RAMWR/RDID.
// Optional read path and RDID are built only when NH_LCD_RESPONDER_READ_EN is defined.
module nh_lcd_bus_responder #(
  parameter int          MAX_COL  = 239,
  parameter int          MAX_ROW  = 319,
  parameter logic [23:0] ID_VALUE = 24'h009341
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_cs_n,
  input  logic        i_wr_n,
  input  logic        i_rd_n,
  input  logic        i_dc,
  input  logic [7:0]  i_data,
  output logic [7:0]  o_data,
  output logic        o_data_oe,
  output logic [7:0]  o_cmd,
  output logic        o_cmd_stb,
  output logic        o_pix_stb,
  output logic [15:0] o_pix_data,
  output logic [8:0]  o_pix_x,
  output logic [8:0]  o_pix_y,
  output logic [31:0] debug
);

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_CASET = 4'd1,
    ST_PASET = 4'd2,
    ST_RAMWR = 4'd3,
    ST_RDID  = 4'd4
  } state_t;

  localparam logic [8:0] MAX_COL_V = 9'(MAX_COL);
  localparam logic [8:0] MAX_ROW_V = 9'(MAX_ROW);

  state_t      state, state_nxt;
  logic [1:0]  cs_sy, wr_sy, rd_sy, dc_sy;
  logic [7:0]  d_sy1, d_sy2;
  logic        cs_s, wr_s, rd_s;
  logic        wr_q, conflict, conflict_q, quiet, wr_edge;
  logic        wr_evt, wr_dc;
  logic [7:0]  wr_byte;
  logic [7:0]  err_cnt;
  logic [2:0]  idx;
  logic [7:0]  p0, p1, p2, hi;
  logic        phase;
  logic [8:0]  col_start, col_end, row_start, row_end, x, y;
  logic [8:0]  lim, s_clamp, e_clamp, e_fix;
  logic [15:0] p_start, p_end;

  assign cs_s = cs_sy[1];
  assign wr_s = wr_sy[1];
  assign rd_s = rd_sy[1];

  // Both strobes low is a host protocol error; edges around it are discarded.
  assign conflict = ~wr_s & ~rd_s & ~cs_s;
  assign quiet    = conflict | conflict_q;
  assign wr_edge  = wr_s & ~wr_q & ~cs_s & ~quiet;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_sy      <= 2'b11;
      wr_sy      <= 2'b11;
      rd_sy      <= 2'b11;
      dc_sy      <= 2'b00;
      d_sy1      <= '0;
      d_sy2      <= '0;
      wr_q       <= 1'b1;
      conflict_q <= 1'b0;
      wr_evt     <= 1'b0;
      wr_dc      <= 1'b0;
      wr_byte    <= '0;
    end else begin
      cs_sy      <= {cs_sy[0], i_cs_n};
      wr_sy      <= {wr_sy[0], i_wr_n};
      rd_sy      <= {rd_sy[0], i_rd_n};
      dc_sy      <= {dc_sy[0], i_dc};
      d_sy1      <= i_data;
      d_sy2      <= d_sy1;
      wr_q       <= wr_s;
      conflict_q <= conflict;
      wr_evt     <= wr_edge;
      wr_dc      <= dc_sy[1];
      wr_byte    <= d_sy2;
    end
  end

`ifdef NH_LCD_RESPONDER_READ_EN
  logic       rd_q, rds_edge, rde_edge, rds_evt, rde_evt, rd_active;
  logic [7:0] id_byte;

  assign rds_edge = ~rd_s & rd_q & ~cs_s & ~quiet;
  // Read-end is not gated by cs so an open read can always close.
  assign rde_edge = rd_s & ~rd_q;

  always_comb begin
    id_byte = 8'h00;
    case (idx)
      3'd1:    id_byte = ID_VALUE[23:16];
      3'd2:    id_byte = ID_VALUE[15:8];
      3'd3:    id_byte = ID_VALUE[7:0];
      default: id_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q    <= 1'b1;
      rds_evt <= 1'b0;
      rde_evt <= 1'b0;
    end else begin
      rd_q    <= rd_s;
      rds_evt <= rds_edge;
      rde_evt <= rde_edge;
    end
  end
`else
  assign o_data    = 8'h00;
  assign o_data_oe = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (wr_evt && !wr_dc) begin
      case (wr_byte)
        8'h2A:   state_nxt = ST_CASET;
        8'h2B:   state_nxt = ST_PASET;
        8'h2C:   state_nxt = ST_RAMWR;
`ifdef NH_LCD_RESPONDER_READ_EN
        8'h04:   state_nxt = ST_RDID;
`endif
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Window bounds from the 4th parameter byte: clamp, then end never below start.
  always_comb begin
    lim     = (state == ST_CASET) ? MAX_COL_V : MAX_ROW_V;
    p_start = {p0, p1};
    p_end   = {p2, wr_byte};
    s_clamp = (p_start > {7'd0, lim}) ? lim : p_start[8:0];
    e_clamp = (p_end > {7'd0, lim}) ? lim : p_end[8:0];
    e_fix   = (e_clamp < s_clamp) ? s_clamp : e_clamp;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_cmd      <= '0;
      o_cmd_stb  <= 1'b0;
      o_pix_stb  <= 1'b0;
      o_pix_data <= '0;
      o_pix_x    <= '0;
      o_pix_y    <= '0;
      err_cnt    <= '0;
      idx        <= '0;
      p0         <= '0;
      p1         <= '0;
      p2         <= '0;
      hi         <= '0;
      phase      <= 1'b0;
      col_start  <= '0;
      col_end    <= MAX_COL_V;
      row_start  <= '0;
      row_end    <= MAX_ROW_V;
      x          <= '0;
      y          <= '0;
`ifdef NH_LCD_RESPONDER_READ_EN
      o_data     <= '0;
      o_data_oe  <= 1'b0;
      rd_active  <= 1'b0;
`endif
    end else begin
      o_cmd_stb <= 1'b0;
      o_pix_stb <= 1'b0;
      if (conflict && !conflict_q && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;

`ifdef NH_LCD_RESPONDER_READ_EN
      if (conflict) begin
        o_data_oe <= 1'b0;
        o_data    <= '0;
        rd_active <= 1'b0;
      end else if (rds_evt) begin
        rd_active <= 1'b1;
        o_data_oe <= 1'b1;
        o_data    <= (state == ST_RDID) ? id_byte : 8'h00;
      end else if (rde_evt && rd_active) begin
        rd_active <= 1'b0;
        o_data_oe <= 1'b0;
        o_data    <= '0;
        if (state == ST_RDID && idx != 3'd4) idx <= idx + 3'd1;
      end
`endif

      // Write handling comes last so a command wins over a same-cycle read end.
      if (wr_evt) begin
        if (!wr_dc) begin
          o_cmd     <= wr_byte;
          o_cmd_stb <= 1'b1;
          idx       <= '0;
          phase     <= 1'b0;
          x         <= col_start;
          y         <= row_start;
        end else begin
          case (state)
            ST_CASET, ST_PASET: begin
              case (idx)
                3'd0: p0 <= wr_byte;
                3'd1: p1 <= wr_byte;
                3'd2: p2 <= wr_byte;
                3'd3: begin
                  if (state == ST_CASET) begin
                    col_start <= s_clamp;
                    col_end   <= e_fix;
                  end else begin
                    row_start <= s_clamp;
                    row_end   <= e_fix;
                  end
                end
                default: ;
              endcase
              if (idx != 3'd4) idx <= idx + 3'd1;
            end
            ST_RAMWR: begin
              if (!phase) begin
                hi    <= wr_byte;
                phase <= 1'b1;
              end else begin
                o_pix_stb  <= 1'b1;
                o_pix_data <= {hi, wr_byte};
                o_pix_x    <= x;
                o_pix_y    <= y;
                phase      <= 1'b0;
                if (x == col_end) begin
                  x <= col_start;
                  y <= (y == row_end) ? row_start : y + 9'd1;
                end else begin
                  x <= x + 9'd1;
                end
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign debug = {8'h00, err_cnt, o_cmd, 1'b0, idx, state};

endmodule

// File: tb/tb_nh_lcd_bus_responder.sv
// Directed bench for nh_lcd_bus_responder: window decode, pixel assembly, abort, RDID, strobe errors.
module tb_nh_lcd_bus_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_cs_n, i_wr_n, i_rd_n, i_dc;
  logic [7:0]  i_data;
  logic [7:0]  o_data;
  logic        o_data_oe;
  logic [7:0]  o_cmd;
  logic        o_cmd_stb, o_pix_stb;
  logic [15:0] o_pix_data;
  logic [8:0]  o_pix_x, o_pix_y;
  logic [31:0] debug;

  int checks = 0;
  int failures = 0;
  int cmd_cnt = 0;
  logic [33:0] px_q[$];

`ifdef NH_LCD_RESPONDER_READ_EN
  localparam bit READ_EN = 1'b1;
`else
  localparam bit READ_EN = 1'b0;
`endif
  localparam logic [3:0] RDID_ST = READ_EN ? 4'd4 : 4'd0;

  nh_lcd_bus_responder dut (
    .clk(clk), .rst(rst), .i_cs_n(i_cs_n), .i_wr_n(i_wr_n), .i_rd_n(i_rd_n),
    .i_dc(i_dc), .i_data(i_data), .o_data(o_data), .o_data_oe(o_data_oe),
    .o_cmd(o_cmd), .o_cmd_stb(o_cmd_stb), .o_pix_stb(o_pix_stb),
    .o_pix_data(o_pix_data), .o_pix_x(o_pix_x), .o_pix_y(o_pix_y), .debug(debug)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_pix_stb) px_q.push_back({o_pix_data, o_pix_x, o_pix_y});
    if (o_cmd_stb) cmd_cnt++;
  end

  task automatic wr_byte(input logic dc, input logic [7:0] d);
    i_dc = dc; i_data = d; i_wr_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 i_wr_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic rd_cycle(output logic [7:0] d, output logic oe_mid, output logic oe_after);
    i_rd_n = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    oe_mid = o_data_oe; d = o_data;
    @(posedge clk);
    #1 i_rd_n = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    oe_after = o_data_oe;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_cs_n = 1'b1; i_wr_n = 1'b1; i_rd_n = 1'b1; i_dc = 1'b0; i_data = 8'h00;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (o_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", o_data); end
    checks++; if (o_data_oe !== 1'b0) begin failures++; $display("FAIL reset_oe got=%b exp=0", o_data_oe); end
    checks++; if (o_cmd !== 8'h00) begin failures++; $display("FAIL reset_cmd got=%h exp=00", o_cmd); end
    checks++; if ({o_cmd_stb, o_pix_stb} !== 2'b00) begin failures++; $display("FAIL reset_stb got=%b exp=00", {o_cmd_stb, o_pix_stb}); end
    checks++; if ({o_pix_data, o_pix_x, o_pix_y} !== 34'd0) begin failures++; $display("FAIL reset_pix got=%h exp=0", {o_pix_data, o_pix_x, o_pix_y}); end
    checks++; if (debug !== 32'd0) begin failures++; $display("FAIL reset_debug got=%h exp=0", debug); end
    @(posedge clk); #1 i_cs_n = 1'b0;
    repeat (4) @(posedge clk); #1;
  endtask

  task automatic test_ramwr_basic();
    int c0;
    px_q.delete(); c0 = cmd_cnt;
    wr_byte(0, 8'h2C); wr_byte(1, 8'hF8); wr_byte(1, 8'h00); wr_byte(1, 8'h07); wr_byte(1, 8'hE0);
    checks++; if (px_q.size() != 2) begin failures++; $display("FAIL basic_count got=%0d exp=2", px_q.size()); end
    checks++; if (px_q.size() > 0 && px_q[0] !== {16'hF800, 9'd0, 9'd0}) begin failures++; $display("FAIL basic_px0 got=%h exp=%h", px_q[0], {16'hF800, 9'd0, 9'd0}); end
    checks++; if (px_q.size() > 1 && px_q[1] !== {16'h07E0, 9'd1, 9'd0}) begin failures++; $display("FAIL basic_px1 got=%h exp=%h", px_q[1], {16'h07E0, 9'd1, 9'd0}); end
    checks++; if (debug[3:0] !== 4'd3) begin failures++; $display("FAIL basic_state got=%0d exp=3", debug[3:0]); end
    checks++; if (o_cmd !== 8'h2C) begin failures++; $display("FAIL basic_cmd got=%h exp=2c", o_cmd); end
    checks++; if (cmd_cnt - c0 != 1) begin failures++; $display("FAIL basic_cmdstb got=%0d exp=1", cmd_cnt - c0); end
  endtask

  task automatic test_window();
    logic [8:0] ex [5] = '{9'd10, 9'd11, 9'd10, 9'd11, 9'd10};
    logic [8:0] ey [5] = '{9'd5, 9'd5, 9'd6, 9'd6, 9'd5};
    logic [33:0] e;
    px_q.delete();
    wr_byte(0, 8'h2A); wr_byte(1, 8'h00); wr_byte(1, 8'h0A); wr_byte(1, 8'h00); wr_byte(1, 8'h0B);
    wr_byte(0, 8'h2B); wr_byte(1, 8'h00); wr_byte(1, 8'h05); wr_byte(1, 8'h00); wr_byte(1, 8'h06);
    wr_byte(0, 8'h2C);
    for (int i = 0; i < 5; i++) begin
      wr_byte(1, 8'hA0); wr_byte(1, 8'(i));
    end
    checks++; if (px_q.size() != 5) begin failures++; $display("FAIL win_count got=%0d exp=5", px_q.size()); end
    for (int i = 0; i < 5; i++) begin
      e = {8'hA0, 8'(i), ex[i], ey[i]};
      checks++; if (i >= px_q.size() || px_q[i] !== e) begin failures++; $display("FAIL win_px%0d got=%h exp=%h", i, (i < px_q.size()) ? px_q[i] : 34'h0, e); end
    end
  endtask

  task automatic test_clamp();
    logic [8:0] ey [3] = '{9'd318, 9'd319, 9'd318};
    logic [33:0] e;
    px_q.delete();
    wr_byte(0, 8'h2A); wr_byte(1, 8'h01); wr_byte(1, 8'h20); wr_byte(1, 8'h00); wr_byte(1, 8'h10);
    wr_byte(0, 8'h2B); wr_byte(1, 8'h01); wr_byte(1, 8'h3E); wr_byte(1, 8'hFF); wr_byte(1, 8'hFF);
    wr_byte(1, 8'h00);
    checks++; if (debug[7:4] !== 4'd4) begin failures++; $display("FAIL clamp_pidx got=%0d exp=4", debug[7:4]); end
    wr_byte(0, 8'h2C);
    for (int i = 0; i < 3; i++) begin
      wr_byte(1, 8'hC0); wr_byte(1, 8'(i));
    end
    checks++; if (px_q.size() != 3) begin failures++; $display("FAIL clamp_count got=%0d exp=3", px_q.size()); end
    for (int i = 0; i < 3; i++) begin
      e = {8'hC0, 8'(i), 9'd239, ey[i]};
      checks++; if (i >= px_q.size() || px_q[i] !== e) begin failures++; $display("FAIL clamp_px%0d got=%h exp=%h", i, (i < px_q.size()) ? px_q[i] : 34'h0, e); end
    end
  endtask

  task automatic test_abort();
    int c0;
    px_q.delete(); c0 = cmd_cnt;
    wr_byte(0, 8'h2C); wr_byte(1, 8'hAA); wr_byte(0, 8'h00);
    checks++; if (px_q.size() != 0) begin failures++; $display("FAIL abort_nopix got=%0d exp=0", px_q.size()); end
    checks++; if (debug[3:0] !== 4'd0) begin failures++; $display("FAIL abort_state got=%0d exp=0", debug[3:0]); end
    checks++; if (o_cmd !== 8'h00) begin failures++; $display("FAIL abort_cmd got=%h exp=00", o_cmd); end
    wr_byte(0, 8'h2A); wr_byte(1, 8'h00); wr_byte(1, 8'h05);
    wr_byte(0, 8'h2C); wr_byte(1, 8'h12); wr_byte(1, 8'h34);
    checks++; if (cmd_cnt - c0 != 4) begin failures++; $display("FAIL abort_cmdstb got=%0d exp=4", cmd_cnt - c0); end
    checks++; if (px_q.size() != 1 || px_q[0] !== {16'h1234, 9'd239, 9'd318}) begin failures++; $display("FAIL abort_restart got=%h n=%0d exp=%h", (px_q.size() > 0) ? px_q[0] : 34'h0, px_q.size(), {16'h1234, 9'd239, 9'd318}); end
  endtask

  task automatic test_rst_mid();
    px_q.delete();
    wr_byte(0, 8'h2C); wr_byte(1, 8'h56);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (debug !== 32'd0 || o_cmd !== 8'h00) begin failures++; $display("FAIL rstmid_clear got=%h/%h exp=0/00", debug, o_cmd); end
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(posedge clk); #1;
    wr_byte(0, 8'h2C); wr_byte(1, 8'h9A); wr_byte(1, 8'hBC);
    checks++; if (px_q.size() != 1 || px_q[0] !== {16'h9ABC, 9'd0, 9'd0}) begin failures++; $display("FAIL rstmid_px got=%h n=%0d exp=%h", (px_q.size() > 0) ? px_q[0] : 34'h0, px_q.size(), {16'h9ABC, 9'd0, 9'd0}); end
  endtask

  task automatic test_cs_gate();
    int c0;
    logic [7:0] d;
    logic oe_m, oe_a;
    px_q.delete(); c0 = cmd_cnt;
    wr_byte(0, 8'h2C); wr_byte(1, 8'h11);
    #1 i_cs_n = 1'b1;
    repeat (4) @(posedge clk); #1;
    wr_byte(0, 8'h2A); wr_byte(1, 8'h33);
    rd_cycle(d, oe_m, oe_a);
    checks++; if (oe_m !== 1'b0) begin failures++; $display("FAIL csgate_oe got=%b exp=0", oe_m); end
    i_cs_n = 1'b0;
    repeat (4) @(posedge clk); #1;
    wr_byte(1, 8'h22);
    checks++; if (cmd_cnt - c0 != 1) begin failures++; $display("FAIL csgate_cmdstb got=%0d exp=1", cmd_cnt - c0); end
    checks++; if (o_cmd !== 8'h2C) begin failures++; $display("FAIL csgate_cmd got=%h exp=2c", o_cmd); end
    checks++; if (px_q.size() != 1 || px_q[0] !== {16'h1122, 9'd0, 9'd0}) begin failures++; $display("FAIL csgate_px got=%h n=%0d exp=%h", (px_q.size() > 0) ? px_q[0] : 34'h0, px_q.size(), {16'h1122, 9'd0, 9'd0}); end
  endtask

  task automatic test_rdid();
    logic [7:0] ed [5] = '{8'h00, 8'h00, 8'h93, 8'h41, 8'h00};
    logic [7:0] d, exp_d;
    logic oe_m, oe_a;
    wr_byte(0, 8'h04);
    checks++; if (o_cmd !== 8'h04) begin failures++; $display("FAIL rdid_cmd got=%h exp=04", o_cmd); end
    checks++; if (debug[3:0] !== RDID_ST) begin failures++; $display("FAIL rdid_state got=%0d exp=%0d", debug[3:0], RDID_ST); end
    for (int i = 0; i < 5; i++) begin
      rd_cycle(d, oe_m, oe_a);
      exp_d = READ_EN ? ed[i] : 8'h00;
      checks++; if (d !== exp_d) begin failures++; $display("FAIL rdid_data%0d got=%h exp=%h", i, d, exp_d); end
      checks++; if (oe_m !== READ_EN) begin failures++; $display("FAIL rdid_oe%0d got=%b exp=%b", i, oe_m, READ_EN); end
      checks++; if (oe_a !== 1'b0) begin failures++; $display("FAIL rdid_oeoff%0d got=%b exp=0", i, oe_a); end
    end
  endtask

  task automatic test_conflict();
    int c0;
    logic [7:0] d;
    logic oe_m, oe_a;
    px_q.delete(); c0 = cmd_cnt;
    i_dc = 1'b0; i_data = 8'h2C;
    i_wr_n = 1'b0; i_rd_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (o_data_oe !== 1'b0) begin failures++; $display("FAIL conflict_oe got=%b exp=0", o_data_oe); end
    @(posedge clk); #1 i_wr_n = 1'b1; i_rd_n = 1'b1;
    repeat (6) @(posedge clk); #1;
    checks++; if (debug[23:16] !== 8'd1) begin failures++; $display("FAIL conflict_err got=%0d exp=1", debug[23:16]); end
    checks++; if (debug[3:0] !== RDID_ST) begin failures++; $display("FAIL conflict_state got=%0d exp=%0d", debug[3:0], RDID_ST); end
    checks++; if (cmd_cnt != c0 || px_q.size() != 0) begin failures++; $display("FAIL conflict_quiet got=%0d/%0d exp=0/0", cmd_cnt - c0, px_q.size()); end
    i_cs_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    wr_byte(0, 8'h2B); wr_byte(1, 8'h01);
    rd_cycle(d, oe_m, oe_a);
    i_cs_n = 1'b0;
    repeat (4) @(posedge clk); #1;
    checks++; if (cmd_cnt != c0 || o_cmd !== 8'h04) begin failures++; $display("FAIL csoff_cmd got=%0d/%h exp=0/04", cmd_cnt - c0, o_cmd); end
    checks++; if (debug[23:16] !== 8'd1 || debug[3:0] !== RDID_ST) begin failures++; $display("FAIL csoff_state got=%h exp_err=1 exp_st=%0d", debug, RDID_ST); end
    checks++; if (oe_m !== 1'b0) begin failures++; $display("FAIL csoff_oe got=%b exp=0", oe_m); end
  endtask

  initial begin
    test_reset();
    test_ramwr_basic();
    test_window();
    test_clamp();
    test_abort();
    test_rst_mid();
    test_cs_gate();
    test_rdid();
    test_conflict();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
